conv_twos: RTL and testbench

CONV_TWOS -- requirements
Module: conv_twos

---
 rtl/conv_twos.sv | 101 ++++++++++
 tb/tb_conv_twos.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/conv_twos.sv
// Sign-magnitude to two's-complement converter with a small output FIFO.
// Converted words are registered into a circular buffer; the head is presented on tx10.
module conv_twos #(
  parameter int MAG_W = 17,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [MAG_W-1:0] in_mag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAG_W:0]   tx10,
  output logic             negzero,
  output logic [15:0]      conv_count,
  output logic [7:0]       negzero_count
);

  localparam int OUT_W = MAG_W + 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [OUT_W-1:0] data_mem [DEPTH];
  logic             nz_mem   [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] occ_reg, occ_next;
  logic [15:0]      conv_count_reg;
  logic [7:0]       negzero_count_reg;

  logic             push;
  logic             pop;
  logic [OUT_W-1:0] mag_ext;
  logic [OUT_W-1:0] conv_word;
  logic             conv_nz;

  // Handshake qualifiers come from registered occupancy only.
  assign in_ready  = (occ_reg < CNT_W'(DEPTH));
  assign out_valid = (occ_reg != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Negative zero falls out of ~0+1 wrapping to 0; it is flagged separately.
  assign mag_ext   = {1'b0, in_mag};
  assign conv_word = in_sign ? (~mag_ext + OUT_W'(1)) : mag_ext;
  assign conv_nz   = in_sign & (in_mag == '0);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    occ_next    = occ_reg;
    if (push) begin
      wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_next = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   occ_next = occ_reg + CNT_W'(1);
      2'b01:   occ_next = occ_reg - CNT_W'(1);
      default: occ_next = occ_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      occ_reg           <= '0;
      conv_count_reg    <= '0;
      negzero_count_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      occ_reg    <= occ_next;
      if (push) begin
        conv_count_reg <= conv_count_reg + 16'd1;
        if (conv_nz && negzero_count_reg != 8'hFF) begin
          negzero_count_reg <= negzero_count_reg + 8'd1;
        end
      end
    end
  end

  // Storage needs no reset: the head is masked whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      data_mem[wr_ptr_reg] <= conv_word;
      nz_mem[wr_ptr_reg]   <= conv_nz;
    end
  end

  assign tx10          = out_valid ? data_mem[rd_ptr_reg] : '0;
  assign negzero       = out_valid ? nz_mem[rd_ptr_reg] : 1'b0;
  assign conv_count    = conv_count_reg;
  assign negzero_count = negzero_count_reg;

endmodule

// File: tb/tb_conv_twos.sv
// Directed bench for conv_twos: conversion values, negative zero, backpressure,
// toggling consumer against a queue model, and mid-operation reset.
module tb_conv_twos;

  localparam int MAG_W = 17;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [MAG_W-1:0] in_mag;
  logic             out_valid;
  logic             out_ready;
  logic [MAG_W:0]   tx10;
  logic             negzero;
  logic [15:0]      conv_count;
  logic [7:0]       negzero_count;

  int vectors = 0;
  int miscompares = 0;

  conv_twos #(.MAG_W(MAG_W), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign), .in_mag(in_mag),
    .out_valid(out_valid), .out_ready(out_ready), .tx10(tx10), .negzero(negzero),
    .conv_count(conv_count), .negzero_count(negzero_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_mag = '0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [MAG_W:0] ref_conv(input logic s, input logic [MAG_W-1:0] m);
    logic [MAG_W:0] z;
    z = '0;
    return s ? (z - {1'b0, m}) : {1'b0, m};
  endfunction

  task automatic test_reset();
    do_reset();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vectors++; if (tx10 !== 18'h0 || negzero !== 1'b0) begin miscompares++; $display("FAIL reset_head got %h/%b want 0/0", tx10, negzero); end
    vectors++; if (conv_count !== 16'h0 || negzero_count !== 8'h0) begin miscompares++; $display("FAIL reset_counts got %h/%h want 0/0", conv_count, negzero_count); end
  endtask

  task automatic test_basic();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_sign = 1'b1; in_mag = 17'h000A0;
    tick();
    vectors++; if (out_valid !== 1'b1 || tx10 !== 18'h3FF60) begin miscompares++; $display("FAIL basic_neg10 got v=%b %h want v=1 3ff60", out_valid, tx10); end
    in_sign = 1'b0; in_mag = 17'h00320;
    tick();
    vectors++; if (out_valid !== 1'b1 || tx10 !== 18'h00320) begin miscompares++; $display("FAIL basic_pos50 got v=%b %h want v=1 00320", out_valid, tx10); end
    in_valid = 1'b0;
    tick();
    vectors++; if (out_valid !== 1'b0 || tx10 !== 18'h0) begin miscompares++; $display("FAIL basic_empty got v=%b %h want v=0 0", out_valid, tx10); end
    vectors++; if (conv_count !== 16'd2) begin miscompares++; $display("FAIL basic_count got %0d want 2", conv_count); end
  endtask

  task automatic test_extremes();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_sign = 1'b1; in_mag = 17'h1FFFF;
    tick();
    vectors++; if (tx10 !== 18'h20001 || negzero !== 1'b0) begin miscompares++; $display("FAIL max_neg got %h/%b want 20001/0", tx10, negzero); end
    in_sign = 1'b0;
    tick();
    vectors++; if (tx10 !== 18'h1FFFF || negzero !== 1'b0) begin miscompares++; $display("FAIL max_pos got %h/%b want 1ffff/0", tx10, negzero); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_negzero();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_sign = 1'b1; in_mag = '0;
    tick();
    vectors++; if (out_valid !== 1'b1 || tx10 !== 18'h0 || negzero !== 1'b1) begin miscompares++; $display("FAIL negzero_head got v=%b %h/%b want v=1 0/1", out_valid, tx10, negzero); end
    vectors++; if (negzero_count !== 8'd1) begin miscompares++; $display("FAIL negzero_count got %0d want 1", negzero_count); end
    in_sign = 1'b0;
    tick();
    vectors++; if (tx10 !== 18'h0 || negzero !== 1'b0) begin miscompares++; $display("FAIL poszero got %h/%b want 0/0", tx10, negzero); end
    // Saturation: 300 more negative zeros at one transfer per cycle.
    in_sign = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    in_valid = 1'b0;
    tick();
    vectors++; if (negzero_count !== 8'hFF) begin miscompares++; $display("FAIL negzero_sat got %h want ff", negzero_count); end
    vectors++; if (conv_count !== 16'd302) begin miscompares++; $display("FAIL negzero_conv_count got %0d want 302", conv_count); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_sign = 1'b0; in_mag = 17'h00010;
    tick();
    vectors++; if (in_ready !== 1'b1 || tx10 !== 18'h00010) begin miscompares++; $display("FAIL bp_first got rdy=%b %h want rdy=1 00010", in_ready, tx10); end
    in_sign = 1'b1; in_mag = 17'h00001;
    tick();
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_full got rdy=%b want 0", in_ready); end
    in_sign = 1'b0; in_mag = 17'h12345;
    tick();
    vectors++; if (in_ready !== 1'b0 || tx10 !== 18'h00010 || conv_count !== 16'd2) begin miscompares++; $display("FAIL bp_hold got rdy=%b %h cnt=%0d want rdy=0 00010 cnt=2", in_ready, tx10, conv_count); end
    out_ready = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_first_pop_ready got %b want 0", in_ready); end
    tick();
    vectors++; if (tx10 !== 18'h3FFFF || in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_second got %h rdy=%b want 3ffff rdy=1", tx10, in_ready); end
    tick();
    vectors++; if (tx10 !== 18'h12345) begin miscompares++; $display("FAIL bp_third got %h want 12345", tx10); end
    in_valid = 1'b0;
    tick();
    vectors++; if (out_valid !== 1'b0 || conv_count !== 16'd3) begin miscompares++; $display("FAIL bp_drain got v=%b cnt=%0d want v=0 cnt=3", out_valid, conv_count); end
  endtask

  task automatic test_toggle();
    logic [MAG_W:0] exp_q[$];
    logic           nz_q[$];
    int             xfers;
    do_reset();
    xfers = 0;
    for (int c = 0; c < 40; c++) begin
      in_valid  = 1'b1;
      in_sign   = (c % 3 == 0);
      in_mag    = 17'(c * 137);
      out_ready = c[0];
      #1;
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0 || tx10 !== exp_q[0] || negzero !== nz_q[0]) begin
          miscompares++; $display("FAIL toggle_out got %h/%b want %h/%b", tx10, negzero,
                                  (exp_q.size() != 0) ? exp_q[0] : 18'h0, (nz_q.size() != 0) ? nz_q[0] : 1'b0);
        end else $display("out %h nz=%b", tx10, negzero);
        if (exp_q.size() != 0) begin void'(exp_q.pop_front()); void'(nz_q.pop_front()); end
      end
      if (in_ready) begin
        exp_q.push_back(ref_conv(in_sign, in_mag));
        nz_q.push_back(in_sign && in_mag == '0);
        xfers++;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 8 && exp_q.size() != 0; c++) begin
      vectors++;
      if (out_valid !== 1'b1 || tx10 !== exp_q[0] || negzero !== nz_q[0]) begin
        miscompares++; $display("FAIL toggle_drain got v=%b %h/%b want v=1 %h/%b", out_valid, tx10, negzero, exp_q[0], nz_q[0]);
      end else $display("out %h nz=%b", tx10, negzero);
      void'(exp_q.pop_front()); void'(nz_q.pop_front());
      tick();
    end
    vectors++; if (exp_q.size() != 0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL toggle_empty got left=%0d v=%b want 0/0", exp_q.size(), out_valid); end
    vectors++; if (conv_count !== 16'(xfers)) begin miscompares++; $display("FAIL toggle_count got %0d want %0d", conv_count, xfers); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_sign = 1'b1; in_mag = '0;
    tick();
    tick();
    vectors++; if (in_ready !== 1'b0 || conv_count !== 16'd2) begin miscompares++; $display("FAIL mid_fill got rdy=%b cnt=%0d want 0/2", in_ready, conv_count); end
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b0 || tx10 !== 18'h0 || negzero !== 1'b0) begin miscompares++; $display("FAIL mid_flush got v=%b %h/%b want 0 0/0", out_valid, tx10, negzero); end
    vectors++; if (conv_count !== 16'd0 || negzero_count !== 8'd0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_counts got %0d/%0d rdy=%b want 0/0 rdy=1", conv_count, negzero_count, in_ready); end
    in_valid = 1'b1; in_sign = 1'b1; in_mag = 17'h00010;
    tick();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1 || tx10 !== 18'h3FFF0 || conv_count !== 16'd1) begin miscompares++; $display("FAIL mid_after got v=%b %h cnt=%0d want 1 3fff0 1", out_valid, tx10, conv_count); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_negzero();
    test_backpressure();
    test_toggle();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
